// File: rtl/peak_reporter_pkg.sv
// Shared constants, FSM state type and digit-count helper for peak_reporter.
// Imported by the top and the nibble-to-ASCII sub-module.
package peak_reporter_pkg;

  localparam logic [7:0] ASCII_C    = 8'h43;
  localparam logic [7:0] ASCII_EQ   = 8'h3D;
  localparam logic [7:0] ASCII_AT   = 8'h40;
  localparam logic [7:0] ASCII_DASH = 8'h2D;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic {
    IDLE,
    EMIT
  } state_t;

  function automatic int hex_digits(input int w);
    return (w + 3) / 4;
  endfunction

endpackage

// File: rtl/peak_reporter_hex_ascii.sv
// hex_ascii: 4-bit nibble to uppercase ASCII hex digit, combinational.
// Ports: nib (4-bit nibble in), ascii (8-bit character out).
module hex_ascii
  import peak_reporter_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] ascii
);

  always_comb begin
    if (nib < 4'd10) ascii = 8'h30 + {4'h0, nib};
    else             ascii = 8'h37 + {4'h0, nib};
  end

endmodule

// File: rtl/peak_reporter.sv
// peak_reporter: per-channel peak/index tracker with ASCII report streamer.
// Ports: clk, rst (async high), clear, s_valid/s_ch/s_data sample in,
//   report start, tx_valid/tx_ready/tx_byte byte out, busy, done,
//   peak_data/peak_idx live peaks. Macro PEAK_TIE_LATEST_EN: ties take
//   the latest index instead of the first.
module peak_reporter
  import peak_reporter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4,
  parameter int NUM_CH = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     s_valid,
  input  logic [CH_W-1:0]          s_ch,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     report,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [7:0]               tx_byte,
  output logic                     busy,
  output logic                     done,
  output logic [NUM_CH*DATA_W-1:0] peak_data,
  output logic [NUM_CH*IDX_W-1:0]  peak_idx
);

  localparam int HEX_D   = hex_digits(DATA_W);
  localparam int IDX_D   = hex_digits(IDX_W);
  localparam int VW      = HEX_D * 4;
  localparam int IW      = IDX_D * 4;
  localparam int REC_LEN = 6 + HEX_D + IDX_D;
  localparam int POS_W   = $clog2(REC_LEN);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              done_d;
  logic              start;

  logic [DATA_W-1:0] pk      [NUM_CH];
  logic [IDX_W-1:0]  pi      [NUM_CH];
  logic [IDX_W-1:0]  cnt     [NUM_CH];
  logic              has     [NUM_CH];
  logic [DATA_W-1:0] snap_pk [NUM_CH];
  logic [IDX_W-1:0]  snap_pi [NUM_CH];
  logic              snap_has[NUM_CH];

  assign start = (state_q == IDLE) && report;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             hit;
    logic             take;
    logic [IDX_W-1:0] cur;

    assign hit = s_valid && (s_ch == CH_W'(g));
    // A clear in the same cycle makes this sample the first one.
    assign cur = clear ? '0 : cnt[g];
`ifdef PEAK_TIE_LATEST_EN
    assign take = clear || !has[g] || (s_data >= pk[g]);
`else
    assign take = clear || !has[g] || (s_data > pk[g]);
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pk[g]       <= '0;
        pi[g]       <= '0;
        cnt[g]      <= '0;
        has[g]      <= 1'b0;
        snap_pk[g]  <= '0;
        snap_pi[g]  <= '0;
        snap_has[g] <= 1'b0;
      end else begin
        if (clear) begin
          pk[g]  <= '0;
          pi[g]  <= '0;
          cnt[g] <= '0;
          has[g] <= 1'b0;
        end
        if (hit) begin
          has[g] <= 1'b1;
          cnt[g] <= (&cur) ? cur : cur + 1'b1;
          if (take) begin
            pk[g] <= s_data;
            pi[g] <= cur;
          end
        end
        if (start) begin
          snap_pk[g]  <= pk[g];
          snap_pi[g]  <= pi[g];
          snap_has[g] <= has[g];
        end
      end
    end

    assign peak_data[g*DATA_W +: DATA_W] = pk[g];
    assign peak_idx[g*IDX_W +: IDX_W]    = pi[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pos_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pos_q   <= pos_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pos_d   = pos_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (report) begin
          state_d = EMIT;
          ch_d    = '0;
          pos_d   = '0;
        end
      end
      EMIT: begin
        if (tx_ready) begin
          if (pos_q == POS_W'(REC_LEN - 1)) begin
            pos_d = '0;
            if (ch_q == CH_W'(NUM_CH - 1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid = (state_q == EMIT);
  assign busy     = (state_q == EMIT);

  logic [VW-1:0] v_ext;
  logic [IW-1:0] i_ext;
  logic          cur_has;
  logic [3:0]    nib;
  logic [7:0]    lit;
  logic          use_hex;
  logic [7:0]    hex_out;
  int            p;

  assign v_ext   = VW'(snap_pk[ch_q]);
  assign i_ext   = IW'(snap_pi[ch_q]);
  assign cur_has = snap_has[ch_q];

  // Record layout: C ch = value @ index CR LF, digits MSB first.
  always_comb begin
    p       = int'(pos_q);
    nib     = '0;
    lit     = ASCII_LF;
    use_hex = 1'b0;
    if (p == 0) begin
      lit = ASCII_C;
    end else if (p == 1) begin
      use_hex = 1'b1;
      nib     = 4'(ch_q);
    end else if (p == 2) begin
      lit = ASCII_EQ;
    end else if (p < 3 + HEX_D) begin
      if (cur_has) begin
        use_hex = 1'b1;
        nib     = 4'(v_ext >> (4 * (HEX_D + 2 - p)));
      end else begin
        lit = ASCII_DASH;
      end
    end else if (p == 3 + HEX_D) begin
      lit = ASCII_AT;
    end else if (p < 4 + HEX_D + IDX_D) begin
      if (cur_has) begin
        use_hex = 1'b1;
        nib     = 4'(i_ext >> (4 * (IDX_D + HEX_D + 3 - p)));
      end else begin
        lit = ASCII_DASH;
      end
    end else if (p == REC_LEN - 2) begin
      lit = ASCII_CR;
    end else begin
      lit = ASCII_LF;
    end
  end

  hex_ascii u_hex (
    .nib   (nib),
    .ascii (hex_out)
  );

  assign tx_byte = tx_valid ? (use_hex ? hex_out : lit) : 8'h00;

endmodule

// File: tb/tb_peak_reporter.sv
// Self-checking bench for peak_reporter (DATA_W=8, IDX_W=4, NUM_CH=2),
// plus a NUM_CH=3 instance for out-of-range channel ids.
module tb_peak_reporter;

  logic        clk = 0;
  logic        rst = 1;
  logic        clear = 0;
  logic        s_valid = 0;
  logic        s_ch = 0;
  logic [7:0]  s_data = 0;
  logic        report = 0;
  logic        tx_ready = 0;
  logic        tx_valid;
  logic [7:0]  tx_byte;
  logic        busy;
  logic        done;
  logic [15:0] peak_data;
  logic [7:0]  peak_idx;

  logic        s3_valid = 0;
  logic [1:0]  s3_ch = 0;
  logic [7:0]  s3_data = 0;
  logic        tx_valid3;
  logic [7:0]  tx_byte3;
  logic        busy3;
  logic        done3;
  logic [23:0] peak_data3;
  logic [11:0] peak_idx3;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic [7:0] mpk[2];
  logic [3:0] mpi[2];
  logic [3:0] mcnt[2];
  bit         mhas[2];

  always #5 clk = ~clk;

  peak_reporter #(.DATA_W(8), .IDX_W(4), .NUM_CH(2)) dut (
    .clk(clk), .rst(rst), .clear(clear), .s_valid(s_valid),
    .s_ch(s_ch), .s_data(s_data), .report(report),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .busy(busy), .done(done), .peak_data(peak_data),
    .peak_idx(peak_idx)
  );

  peak_reporter #(.DATA_W(8), .IDX_W(4), .NUM_CH(3)) dut3 (
    .clk(clk), .rst(rst), .clear(1'b0), .s_valid(s3_valid),
    .s_ch(s3_ch), .s_data(s3_data), .report(1'b0),
    .tx_ready(1'b0), .tx_valid(tx_valid3), .tx_byte(tx_byte3),
    .busy(busy3), .done(done3), .peak_data(peak_data3),
    .peak_idx(peak_idx3)
  );

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'd48 + 8'(n);
    return 8'd65 + 8'(n) - 8'd10;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mpk[c] = 0; mpi[c] = 0; mcnt[c] = 0; mhas[c] = 0;
    end
  endtask

  task automatic model_sample(input bit clr, input bit vld,
                              input int ch, input logic [7:0] d);
    logic [3:0] cur;
    bit ld;
    if (clr) model_reset();
    if (vld && ch < 2) begin
      cur = mcnt[ch];
      ld = !mhas[ch] || d > mpk[ch];
`ifdef PEAK_TIE_LATEST_EN
      ld = ld || d == mpk[ch];
`endif
      if (ld) begin mpk[ch] = d; mpi[ch] = cur; end
      mhas[ch] = 1;
      if (cur != 4'hF) mcnt[ch] = cur + 1;
    end
  endtask

  task automatic push_expected();
    for (int c = 0; c < 2; c++) begin
      q.push_back("C");
      q.push_back(hexc(4'(c)));
      q.push_back("=");
      q.push_back(mhas[c] ? hexc(mpk[c][7:4]) : "-");
      q.push_back(mhas[c] ? hexc(mpk[c][3:0]) : "-");
      q.push_back("@");
      q.push_back(mhas[c] ? hexc(mpi[c]) : "-");
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endtask

  task automatic send(input bit clr, input bit vld,
                      input int ch, input logic [7:0] d);
    @(posedge clk); #1;
    clear = clr; s_valid = vld; s_ch = 1'(ch); s_data = d;
    model_sample(clr, vld, ch, d);
    @(posedge clk); #1;
    clear = 0; s_valid = 0;
  endtask

  task automatic do_report(input bit toggle, input bit disturb);
    int cyc = 0;
    bit seen = 0;
    bit stalled = 0;
    bit extra = 0;
    logic [7:0] held = 0;
    logic [7:0] ex;
    @(posedge clk); #1;
    report = 1; tx_ready = 1;
    push_expected();
    @(posedge clk); #1;
    report = 0;
    @(negedge clk);
    tests++;
    if (busy !== 1 || tx_valid !== 1) begin
      fails++;
      $display("FAIL start: busy=%b tx_valid=%b want 1 1", busy, tx_valid);
    end
    while (cyc < 300) begin
      if (done) begin
        seen = 1;
        tests++;
        if (tx_valid !== 0 || busy !== 0 || q.size() != 0) begin
          fails++;
          $display("FAIL done_state: tx_valid=%b busy=%b left=%0d want 0 0 0",
                   tx_valid, busy, q.size());
        end
        break;
      end
      if (stalled && tx_valid) begin
        tests++;
        if (tx_byte !== held) begin
          fails++;
          $display("FAIL stall_hold: got %h want %h", tx_byte, held);
        end
      end
      stalled = tx_valid && !tx_ready;
      held = tx_byte;
      if (tx_valid && tx_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_byte: got %h want none", tx_byte);
        end else begin
          ex = q.pop_front();
          if (tx_byte !== ex) begin
            fails++;
            $display("FAIL byte: got %h want %h", tx_byte, ex);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (toggle) tx_ready = ~tx_ready;
      if (disturb) begin
        if (cyc == 5) report = 1;
        if (cyc == 6) report = 0;
        if (cyc == 8) begin
          s_valid = 1; s_ch = 0; s_data = 8'hFF;
          model_sample(0, 1, 0, 8'hFF);
        end
        if (cyc == 9) s_valid = 0;
      end
      @(negedge clk);
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done want done");
    end
    tx_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid || done) extra = 1;
    end
    tests++;
    if (extra) begin
      fails++;
      $display("FAIL quiet_after: got activity want idle");
    end
    q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if (tx_valid !== 0 || busy !== 0 || done !== 0 || tx_byte !== 0) begin
      fails++;
      $display("FAIL reset_ctl: got %b%b%b %h want 000 00",
               tx_valid, busy, done, tx_byte);
    end
    tests++;
    if (peak_data !== 0 || peak_idx !== 0) begin
      fails++;
      $display("FAIL reset_peak: got %h %h want 0 0", peak_data, peak_idx);
    end
    @(posedge clk); #1 rst = 0;
    send(0, 1, 0, 8'h33);
    send(0, 1, 1, 8'h44);
    @(posedge clk); #1 report = 1; tx_ready = 0;
    @(posedge clk); #1 report = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (tx_valid !== 1 || peak_data !== 16'h4433) begin
      fails++;
      $display("FAIL pre_abort: got %b %h want 1 4433", tx_valid, peak_data);
    end
    #2 rst = 1;
    #1;
    tests++;
    if (tx_valid !== 0 || busy !== 0 || done !== 0 ||
        peak_data !== 0 || peak_idx !== 0) begin
      fails++;
      $display("FAIL abort: got %b%b%b %h %h want 000 0 0",
               tx_valid, busy, done, peak_data, peak_idx);
    end
    @(posedge clk); #1 rst = 0;
    model_reset();
  endtask

  task automatic test_report();
    send(0, 1, 0, 8'h12);
    send(0, 1, 0, 8'h7F);
    send(0, 1, 0, 8'h30);
    tests++;
    if (peak_data !== 16'h007F || peak_idx !== 8'h01) begin
      fails++;
      $display("FAIL track: got %h %h want 007f 01", peak_data, peak_idx);
    end
    do_report(0, 0);
  endtask

  task automatic test_tie();
    logic [3:0] want;
`ifdef PEAK_TIE_LATEST_EN
    want = 4'h1;
`else
    want = 4'h0;
`endif
    send(0, 1, 1, 8'h40);
    send(0, 1, 1, 8'h40);
    tests++;
    if (peak_idx[7:4] !== want || peak_data[15:8] !== 8'h40) begin
      fails++;
      $display("FAIL tie: got %h %h want %h 40",
               peak_idx[7:4], peak_data[15:8], want);
    end
  endtask

  task automatic test_back_to_back();
    do_report(1, 1);
    tests++;
    if (peak_data[7:0] !== 8'hFF || peak_idx[3:0] !== 4'h3) begin
      fails++;
      $display("FAIL live_ff: got %h %h want ff 3",
               peak_data[7:0], peak_idx[3:0]);
    end
  endtask

  task automatic test_clear_same();
    send(1, 1, 0, 8'h90);
    send(1, 1, 0, 8'h05);
    tests++;
    if (peak_data !== 16'h0005 || peak_idx !== 8'h00) begin
      fails++;
      $display("FAIL clear_same: got %h %h want 0005 00",
               peak_data, peak_idx);
    end
  endtask

  task automatic test_saturate();
    send(1, 0, 0, 8'h00);
    for (int i = 1; i <= 20; i++) send(0, 1, 0, 8'(i));
    tests++;
    if (peak_data[7:0] !== 8'h14 || peak_idx[3:0] !== 4'hF) begin
      fails++;
      $display("FAIL saturate: got %h %h want 14 f",
               peak_data[7:0], peak_idx[3:0]);
    end
    @(posedge clk); #1;
    s3_valid = 1; s3_ch = 2'd3; s3_data = 8'hEE;
    @(posedge clk); #1;
    s3_valid = 0;
    tests++;
    if (peak_data3 !== 24'h0 || peak_idx3 !== 12'h0) begin
      fails++;
      $display("FAIL bad_ch: got %h %h want 0 0", peak_data3, peak_idx3);
    end
    @(posedge clk); #1;
    s3_valid = 1; s3_ch = 2'd2; s3_data = 8'h11;
    @(posedge clk); #1;
    s3_valid = 0;
    tests++;
    if (peak_data3 !== 24'h110000 || peak_idx3 !== 12'h0) begin
      fails++;
      $display("FAIL ch2_first: got %h %h want 110000 0",
               peak_data3, peak_idx3);
    end
    do_report(0, 0);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_report();
    test_tie();
    test_back_to_back();
    test_clear_same();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
